unidade_controle: RTL
=====================

// Module: unidade_controle
// PURPOSE
//  Multicycle main control FSM for the MIPS datapath. Sequences each instruction
//  FETCH->DECODE->EXEC->MEM->WB and drives datapath strobes. Produces alu_op[1:0],
//  which the ALU-control decoder consumes together with opcode/funct.
//  Handles variable memory latency via mem_ready, with a timeout watchdog.
//  Unsupported instructions and bus timeouts trap to HALT.
// PARAMETERS
//  TIMEOUT  15  max consecutive mem_ready=0 cycles in a memory state; 0 disables watchdog
// PORTS
//  clk          in   1  clock, rising edge
//  reset_n      in   1  asynchronous active-low reset
//  opcode       in   6  IR[31:26], stable from DECODE until return to FETCH
//  funct        in   6  IR[5:0]
//  zero         in   1  ALU zero flag
//  mem_ready    in   1  memory completes the current access this cycle
//  pc_write     out  1  PC load enable
//  i_or_d       out  1  0=PC addresses memory, 1=ALUOut
//  mem_read     out  1  memory read request
//  mem_write    out  1  memory write request
//  ir_write     out  1  IR load enable
//  reg_write    out  1  register file write enable
//  reg_dst      out  1  0=rt, 1=rd
//  mem_to_reg   out  1  0=ALUOut, 1=MDR
//  alu_src_a    out  1  0=PC, 1=A
//  alu_src_b    out  2  00=B, 01=4, 10=sign-ext imm, 11=imm<<2
//  pc_source    out  2  00=ALU result, 01=ALUOut, 10=jump target
//  alu_op       out  2  00=add, 01=sub, 10=decode opcode/funct, 11=none
//  illegal      out  1  sticky: unsupported opcode/funct
//  bus_err      out  1  sticky: memory timeout
//  state        out  4  current state encoding (debug)
// BEHAVIOUR
//  - State register 4 bits; outputs decoded from state; only pc_write/ir_write also
//    depend on mem_ready/zero/opcode. Default for every output not listed is 0.
//  - reset_n=0: state<=RST(0) immediately, wait_cnt, illegal, bus_err <= 0; all outputs 0.
//    RST -> FETCH on the first clk edge after release. Mid-instruction reset aborts cleanly.
//  - States/outputs/transitions:
//    FETCH(1)   mem_read, src_b=01, alu_op=00; if mem_ready: ir_write, pc_write, pc_source=00, ->DECODE
//    DECODE(2)  src_b=11, alu_op=00; opcode 00 with funct in {00,02,03,04,07,20,22,24,26,2A}->R_EXEC;
//               23,2B->MEM_ADDR; 04,05->BRANCH; 02->JUMP; 08,09,0A,0C,0E->I_EXEC;
//               anything else (including an unlisted R funct) -> HALT, illegal<=1
//    MEM_ADDR(3) src_a=1, src_b=10, alu_op=00; 23->MEM_RD, 2B->MEM_WR
//    MEM_RD(4)  mem_read, i_or_d; mem_ready->MEM_WB
//    MEM_WB(5)  reg_write, mem_to_reg; ->FETCH
//    MEM_WR(6)  mem_write, i_or_d; mem_ready->FETCH
//    R_EXEC(7)  src_a=1, src_b=00, alu_op=10; ->R_WB
//    R_WB(8)    reg_write, reg_dst=1; ->FETCH
//    BRANCH(9)  src_a=1, src_b=00, alu_op=01, pc_source=01;
//               pc_write=(op==04&zero)|(op==05&!zero); ->FETCH
//    JUMP(10)   pc_source=10, pc_write; ->FETCH
//    I_EXEC(11) src_a=1, src_b=10, alu_op=10; ->I_WB
//    I_WB(12)   reg_write, reg_dst=0; ->FETCH
//    HALT(15)   all strobes 0, alu_op=11; stays until reset. Codes 13/14 unused -> HALT.
//  - Watchdog: wait_cnt cleared on entry to FETCH/MEM_RD/MEM_WR; +1 each cycle there with
//    mem_ready=0. If TIMEOUT!=0 and wait_cnt==TIMEOUT-1 with mem_ready=0 -> HALT, bus_err<=1.
//    mem_ready=1 on that same cycle wins (normal transition). Counter saturates, no wrap.
//  - Memory requests held stable while waiting; no strobe pulses twice per access.
//  - CPI (mem_ready=1 always): R/I 4, lw 5, sw 4, beq/bne 3, j 3.
// TESTING
//  - Reset then add (op 00, funct 20), mem_ready=1 -> states 0,1,2,7,8,1; alu_op 10 in
//    R_EXEC; reg_write & reg_dst=1 in R_WB only.
//  - lw (op 23), mem_ready low 3 cycles in MEM_RD -> mem_read & i_or_d held 4 cycles;
//    MEM_WB one cycle with mem_to_reg=1.
//  - beq zero=1 -> pc_write=1, pc_source=01 in BRANCH; bne zero=1 -> pc_write=0.
//  - opcode 3F, or op 00 with funct 08 -> HALT, illegal=1, stays 20 cycles; reset_n=0 clears.
//  - TIMEOUT=15, mem_ready=0 in FETCH -> HALT after 15 cycles, bus_err=1; mem_ready=1 on
//    15th cycle -> DECODE instead, bus_err=0.
//  - reset_n asserted mid-MEM_WR -> state=0 and mem_write=0 without a clock edge.

Source files
------------

// File: rtl/unidade_controle.sv
// Multicycle MIPS main control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath strobes and traps unsupported instructions and memory timeouts to HALT.
module unidade_controle #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);

    localparam logic [3:0] S_RST      = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd4;
    localparam logic [3:0] S_MEM_WB   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_R_EXEC   = 4'd7;
    localparam logic [3:0] S_R_WB     = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;
    localparam logic [3:0] S_I_EXEC   = 4'd11;
    localparam logic [3:0] S_I_WB     = 4'd12;
    localparam logic [3:0] S_HALT     = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int              CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit              WD_EN     = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic             in_mem_wait;
    logic             timeout;

    function automatic logic r_funct_ok(input logic [5:0] f);
        case (f)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h07,
            6'h20, 6'h22, 6'h24, 6'h26, 6'h2A: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    assign in_mem_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // mem_ready on the limit cycle takes priority: timeout only fires when it is low
    assign timeout     = WD_EN && (wait_cnt_q == CNT_LIMIT) && !mem_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_RST;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            S_RST:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                                   state_d = r_funct_ok(funct) ? S_R_EXEC : S_HALT;
                    OP_LW, OP_SW:                               state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                             state_d = S_BRANCH;
                    OP_J:                                       state_d = S_JUMP;
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_XORI: state_d = S_I_EXEC;
                    default:                                    state_d = S_HALT;
                endcase
                if (state_d == S_HALT) illegal_d = 1'b1;
            end
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
            end
            S_MEM_WB: state_d = S_FETCH;
            S_R_EXEC: state_d = S_R_WB;
            S_R_WB:   state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_I_EXEC: state_d = S_I_WB;
            S_I_WB:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // Every change of state restarts the wait count, so entry to a memory state starts at zero
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (in_mem_wait && !mem_ready && (wait_cnt_q != CNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_source  = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                pc_write  = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
            end
            S_I_WB:  reg_write = 1'b1;
            S_HALT:  alu_op = 2'b11;
            default: ;
        endcase
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state   = state_q;

endmodule
